// File: rtl/serial_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_bus_pkg
//  Brief    : Shared instruction codes and responder state encoding for the
//             serial bus slave side.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_bus_pkg;

    // Decoded header instruction codes; 2'b01 is reserved and treated as idle
    localparam logic [1:0] INSTR_IDLE  = 2'b00;
    localparam logic [1:0] INSTR_WRITE = 2'b10;
    localparam logic [1:0] INSTR_READ  = 2'b11;

    // Responder sequencing states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_WAIT  = 3'd1,
        ST_WR_MEM   = 3'd2,
        ST_RD_REQ   = 3'd3,
        ST_RD_LATCH = 3'd4,
        ST_RD_TX    = 3'd5,
        ST_FINISH   = 3'd6
    } resp_state_e;

endpackage : serial_bus_pkg
`default_nettype wire

// File: rtl/burst_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : burst_addr_gen
//  Brief    : Burst address/count tracker. Load captures a start address and
//             word count (0 means 1); step advances the address (wrapping)
//             and consumes one word. last flags the final remaining word.
//  Revision : 1.0 - initial release
// ============================================================================
module burst_addr_gen #(
    parameter int ADDR_LEN  = 12,
    parameter int BURST_LEN = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDR_LEN-1:0]  load_addr,
    input  logic [BURST_LEN-1:0] load_count,
    output logic [ADDR_LEN-1:0]  addr,
    output logic                 last
);

    logic [ADDR_LEN-1:0]  addr_q,  addr_d;
    logic [BURST_LEN-1:0] count_q, count_d;

    // Next address/count: load has priority; increment wraps naturally
    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        if (load) begin
            addr_d  = load_addr;
            count_d = (load_count == '0) ? BURST_LEN'(1) : load_count;
        end else if (step) begin
            addr_d  = addr_q + ADDR_LEN'(1);
            count_d = count_q - BURST_LEN'(1);
        end
    end

    // Address/count registers, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign addr = addr_q;
    assign last = (count_q == BURST_LEN'(1));

endmodule : burst_addr_gen
`default_nettype wire

// File: rtl/slave_responder.sv
`default_nettype none
// ============================================================================
//  Module   : slave_responder
//  Brief    : Serial bus slave responder. Executes decoded write/read burst
//             headers against a local memory with one-cycle read latency and
//             hands read words to the slave transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
module slave_responder
    import serial_bus_pkg::*;
#(
    parameter int ADDR_LEN  = 12,
    parameter int DATA_LEN  = 8,
    parameter int BURST_LEN = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_hdr_valid,
    input  logic [1:0]           rx_instr,
    input  logic [ADDR_LEN-1:0]  rx_addr,
    input  logic [BURST_LEN-1:0] rx_burst,
    input  logic                 rx_data_valid,
    input  logic [DATA_LEN-1:0]  rx_data,
    output logic [ADDR_LEN-1:0]  mem_addr,
    output logic [DATA_LEN-1:0]  mem_wdata,
    output logic                 mem_we,
    output logic                 mem_re,
    input  logic [DATA_LEN-1:0]  mem_rdata,
    output logic                 tx_start,
    output logic [DATA_LEN-1:0]  tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 trans_done
);

    resp_state_e         state_q, state_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [DATA_LEN-1:0] tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;

    logic                ag_load;
    logic                ag_step;
    logic                ag_last;
    logic [ADDR_LEN-1:0] ag_addr;

    burst_addr_gen #(
        .ADDR_LEN  (ADDR_LEN),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (ag_load),
        .step       (ag_step),
        .load_addr  (rx_addr),
        .load_count (rx_burst),
        .addr       (ag_addr),
        .last       (ag_last)
    );

    // Next-state and datapath control; tx_start is registered alongside
    // tx_data so the word is stable in the same cycle the pulse appears
    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        ag_load    = 1'b0;
        ag_step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_hdr_valid) begin
                    if (rx_instr == INSTR_WRITE) begin
                        ag_load = 1'b1;
                        state_d = ST_WR_WAIT;
                    end else if (rx_instr == INSTR_READ) begin
                        ag_load = 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (rx_data_valid) begin
                    wdata_d = rx_data;
                    state_d = ST_WR_MEM;
                end
            end
            ST_WR_MEM: begin
                ag_step = 1'b1;
                state_d = ag_last ? ST_FINISH : ST_WR_WAIT;
            end
            ST_RD_REQ: begin
                state_d = ST_RD_LATCH;
            end
            ST_RD_LATCH: begin
                tx_data_d  = mem_rdata;
                tx_start_d = 1'b1;
                state_d    = ST_RD_TX;
            end
            ST_RD_TX: begin
                if (tx_done) begin
                    ag_step = 1'b1;
                    state_d = ag_last ? ST_FINISH : ST_RD_REQ;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and data registers, cleared asynchronously by active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wdata_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    // Strobes decode from distinct states so they can never overlap
    assign mem_addr   = ag_addr;
    assign mem_wdata  = wdata_q;
    assign mem_we     = (state_q == ST_WR_MEM);
    assign mem_re     = (state_q == ST_RD_REQ);
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = (state_q != ST_IDLE);
    assign trans_done = (state_q == ST_FINISH);

endmodule : slave_responder
`default_nettype wire

// File: tb/tb_slave_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slave_responder
//  Brief    : Scoreboard bench for slave_responder: stimulus pushes expected
//             strobe events, a negedge monitor pops and compares them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slave_responder;

    localparam int AL = 12;
    localparam int DL = 8;
    localparam int BL = 12;

    localparam logic [1:0] K_WR = 2'd0;
    localparam logic [1:0] K_RS = 2'd1;
    localparam logic [1:0] K_TX = 2'd2;
    localparam logic [1:0] K_TD = 2'd3;

    typedef struct {
        logic [1:0]    kind;
        logic [AL-1:0] addr;
        logic [DL-1:0] data;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_hdr_valid;
    logic [1:0]    rx_instr;
    logic [AL-1:0] rx_addr;
    logic [BL-1:0] rx_burst;
    logic          rx_data_valid;
    logic [DL-1:0] rx_data;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DL-1:0] mem_rdata;
    logic          tx_start;
    logic [DL-1:0] tx_data;
    logic          tx_done;
    logic          tx_done_auto;
    logic          tx_done_man;
    logic          busy;
    logic          trans_done;

    logic [DL-1:0] mem [0:(1<<AL)-1];
    ev_t           exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    int            last_re_cyc = 0;

    assign tx_done = tx_done_auto | tx_done_man;

    slave_responder #(.ADDR_LEN(AL), .DATA_LEN(DL), .BURST_LEN(BL)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_hdr_valid  (rx_hdr_valid),
        .rx_instr      (rx_instr),
        .rx_addr       (rx_addr),
        .rx_burst      (rx_burst),
        .rx_data_valid (rx_data_valid),
        .rx_data       (rx_data),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .busy          (busy),
        .trans_done    (trans_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Local memory model: synchronous write, one-cycle read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [1:0] k, input logic [AL-1:0] a, input logic [DL-1:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Transmitter model: finishes each word two cycles after tx_start
    initial begin
        tx_done_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start === 1'b1) begin
                @(posedge clk);
                @(posedge clk);
                #1 tx_done_auto = 1'b1;
                @(posedge clk);
                #1 tx_done_auto = 1'b0;
            end
        end
    end

    // Monitor: compare each presented strobe against the scoreboard head
    always @(negedge clk) begin
        int  n;
        ev_t e;
        n = int'(mem_we) + int'(mem_re) + int'(tx_start) + int'(trans_done);
        if (n > 0) begin
            check("strobe_exclusive", 32'(n), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {28'd0, trans_done, tx_start, mem_re, mem_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                if (mem_we) begin
                    check("wr_kind", 32'(e.kind), 32'(K_WR));
                    check("wr_addr", 32'(mem_addr), 32'(e.addr));
                    check("wr_data", 32'(mem_wdata), 32'(e.data));
                end else if (mem_re) begin
                    check("rd_kind", 32'(e.kind), 32'(K_RS));
                    check("rd_addr", 32'(mem_addr), 32'(e.addr));
                    last_re_cyc = cyc;
                end else if (tx_start) begin
                    check("tx_kind", 32'(e.kind), 32'(K_TX));
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("rd_latency", 32'(cyc - last_re_cyc), 32'd2);
                end else begin
                    check("td_kind", 32'(e.kind), 32'(K_TD));
                end
            end
        end
    end

    task automatic hdr(input logic [1:0] ins, input logic [AL-1:0] a, input logic [BL-1:0] b);
        @(posedge clk);
        #1;
        rx_hdr_valid = 1'b1;
        rx_instr     = ins;
        rx_addr      = a;
        rx_burst     = b;
        @(posedge clk);
        #1;
        rx_hdr_valid = 1'b0;
    endtask

    task automatic wdat(input logic [DL-1:0] d);
        @(posedge clk);
        #1;
        rx_data_valid = 1'b1;
        rx_data       = d;
        @(posedge clk);
        #1;
        rx_data_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
        check({tag, "_mem_wdata"},  32'(mem_wdata),  32'd0);
        check({tag, "_tx_data"},    32'(tx_data),    32'd0);
        check({tag, "_strobes"},    {28'd0, trans_done, tx_start, mem_re, mem_we}, 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset         = 1'b0;
        rx_hdr_valid  = 1'b0;
        rx_instr      = 2'b00;
        rx_addr       = '0;
        rx_burst      = '0;
        rx_data_valid = 1'b0;
        rx_data       = '0;
        tx_done_man   = 1'b0;
        for (int i = 0; i < (1 << AL); i++) mem[i] = '0;
        mem[12'h020] = 8'h5A;
        mem[12'h021] = 8'h6B;
        mem[12'h005] = 8'h77;
        mem[12'h030] = 8'h31;
        mem[12'h031] = 8'h32;
        mem[12'h032] = 8'h33;

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Write burst of three
        push(K_WR, 12'h010, 8'hA1);
        push(K_WR, 12'h011, 8'hA2);
        push(K_WR, 12'h012, 8'hA3);
        push(K_TD, '0, '0);
        hdr(2'b10, 12'h010, 12'd3);
        check("wr_busy", 32'(busy), 32'd1);
        wdat(8'hA1);
        wdat(8'hA2);
        wdat(8'hA3);
        drain("wr3_drain", 50);
        check("wr3_mem", {mem[12'h010], mem[12'h011], mem[12'h012]}, 32'h00A1A2A3);

        // Read burst of two
        push(K_RS, 12'h020, '0);
        push(K_TX, '0, 8'h5A);
        push(K_RS, 12'h021, '0);
        push(K_TX, '0, 8'h6B);
        push(K_TD, '0, '0);
        hdr(2'b11, 12'h020, 12'd2);
        drain("rd2_drain", 60);
        check("rd2_idle", 32'(busy), 32'd0);

        // Write wrapping past top of address space
        push(K_WR, 12'hFFF, 8'h11);
        push(K_WR, 12'h000, 8'h22);
        push(K_TD, '0, '0);
        hdr(2'b10, 12'hFFF, 12'd2);
        wdat(8'h11);
        wdat(8'h22);
        drain("wrap_drain", 50);
        check("wrap_mem", {16'd0, mem[12'hFFF], mem[12'h000]}, 32'h00001122);

        // Burst of zero behaves as one word
        push(K_RS, 12'h005, '0);
        push(K_TX, '0, 8'h77);
        push(K_TD, '0, '0);
        hdr(2'b11, 12'h005, 12'd0);
        drain("b0_drain", 50);

        // Reserved instruction and stray data: nothing happens
        hdr(2'b01, 12'h300, 12'd4);
        wdat(8'hEE);
        repeat (3) @(posedge clk);
        #1;
        check("rsv_busy", 32'(busy), 32'd0);

        // Header while busy is ignored; in-flight write completes unchanged
        push(K_WR, 12'h100, 8'hC1);
        push(K_WR, 12'h101, 8'hC2);
        push(K_TD, '0, '0);
        hdr(2'b10, 12'h100, 12'd2);
        hdr(2'b11, 12'h200, 12'd5);
        @(posedge clk);
        #1 tx_done_man = 1'b1;
        @(posedge clk);
        #1 tx_done_man = 1'b0;
        check("busy_mid", 32'(busy), 32'd1);
        wdat(8'hC1);
        wdat(8'hC2);
        drain("ovl_drain", 50);

        // Reset during a three-word read, after the first word completes
        push(K_RS, 12'h030, '0);
        push(K_TX, '0, 8'h31);
        push(K_RS, 12'h031, '0);
        hdr(2'b11, 12'h030, 12'd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_done !== 1'b1 && n < 50);
        check("rst_wait_txdone", 32'(n < 50), 32'd1);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_zero_outputs("midrst");
        check("midrst_queue", 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, busy}, 32'd0);

        push(K_WR, 12'h040, 8'hD4);
        push(K_TD, '0, '0);
        hdr(2'b10, 12'h040, 12'd1);
        wdat(8'hD4);
        drain("postrst_drain", 50);
        check("postrst_mem", 32'(mem[12'h040]), 32'h000000D4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_slave_responder
`default_nettype wire
